// File: rtl/node_port_ctrl.sv
// node_port_ctrl -- node-side endpoint of the router-core node interface.
//
// Outbound: application packets are queued in a TX FIFO and offered to the
// router core one at a time on Packet_From_Node/Packet_From_Node_Valid. Each
// offer is held until Core_Load_Ack; an offer that sees no ack for
// ACK_TIMEOUT cycles is withdrawn for one cycle and retried. After MAX_RETRY
// failed attempts the packet is discarded and tx_err pulses for one cycle.
// Inbound: every Packet_To_Node_Valid cycle pushes Packet_To_Node into an RX
// FIFO (first-word fall-through). A packet arriving while the FIFO is full is
// dropped and the sticky rx_overflow flag is set until reset.
//
// Ports:
//   Clk_R, Rst                      clock (rising edge), async active-high reset
//   app_tx_data/valid/ready         application -> outbound FIFO handshake
//   Packet_From_Node[_Valid]        registered offer to the router core
//   Core_Load_Ack                   router core accepted the offer (1-cycle pulse)
//   Packet_To_Node[_Valid]          inbound packet from the router core
//   app_rx_data/valid/ready         inbound FIFO head -> application handshake
//   tx_err                          1-cycle pulse when a packet is discarded
//   rx_overflow                     sticky inbound-drop flag
//
// Optional build macro NODE_PORT_STATS_EN adds 16-bit saturating counters
// stat_tx_sent, stat_tx_retry, stat_tx_drop and stat_rx_drop.
module node_port_ctrl #(
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic        Clk_R,
  input  logic        Rst,
  input  logic [28:0] app_tx_data,
  input  logic        app_tx_valid,
  output logic        app_tx_ready,
  output logic [28:0] Packet_From_Node,
  output logic        Packet_From_Node_Valid,
  input  logic        Core_Load_Ack,
  input  logic [23:0] Packet_To_Node,
  input  logic        Packet_To_Node_Valid,
  output logic [23:0] app_rx_data,
  output logic        app_rx_valid,
  input  logic        app_rx_ready,
  output logic        tx_err,
`ifdef NODE_PORT_STATS_EN
  output logic        rx_overflow,
  output logic [15:0] stat_tx_sent,
  output logic [15:0] stat_tx_retry,
  output logic [15:0] stat_tx_drop,
  output logic [15:0] stat_rx_drop
`else
  output logic        rx_overflow
`endif
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TW  = $clog2(ACK_TIMEOUT);
  localparam int RW  = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, OFFER, BACKOFF} state_t;

  // ---------------- outbound FIFO ----------------
  logic [28:0]  tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wr, tx_rd;
  logic [TXA:0]   tx_cnt;
  logic           tx_push, tx_pop;

  assign app_tx_ready = (tx_cnt != (TXA+1)'(TX_DEPTH));
  assign tx_push      = app_tx_valid && app_tx_ready;

  always_ff @(posedge Clk_R) begin
    if (tx_push) tx_mem[tx_wr] <= app_tx_data;
  end

  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TXA'(1);
      if (tx_pop)  tx_rd <= tx_rd + TXA'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TXA+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TXA+1)'(1);
        default: ;
      endcase
    end
  end

  // ---------------- outbound offer FSM ----------------
  state_t         state;
  logic [TW-1:0]  timer;
  logic [RW-1:0]  retry;
  logic [RW:0]    retry_p1;
  logic           ack_hit, timeout, last_try;

  // Ack is only meaningful while offering; it takes priority over timeout.
  assign ack_hit  = (state == OFFER) && Core_Load_Ack;
  assign timeout  = (state == OFFER) && !Core_Load_Ack && (timer == TW'(ACK_TIMEOUT - 1));
  assign retry_p1 = {1'b0, retry} + (RW+1)'(1);
  assign last_try = (retry_p1 == (RW+1)'(MAX_RETRY));
  // The head leaves the FIFO on acceptance or on final discard.
  assign tx_pop   = ack_hit || (timeout && last_try);

  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      state                  <= IDLE;
      Packet_From_Node       <= '0;
      Packet_From_Node_Valid <= 1'b0;
      timer                  <= '0;
      retry                  <= '0;
      tx_err                 <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_cnt != '0) begin
            Packet_From_Node       <= tx_mem[tx_rd];
            Packet_From_Node_Valid <= 1'b1;
            timer                  <= '0;
            retry                  <= '0;
            state                  <= OFFER;
          end
        end
        OFFER: begin
          if (ack_hit) begin
            Packet_From_Node_Valid <= 1'b0;
            state                  <= IDLE;
          end else if (timeout) begin
            Packet_From_Node_Valid <= 1'b0;
            if (last_try) begin
              tx_err <= 1'b1;
              state  <= IDLE;
            end else begin
              retry <= retry_p1[RW-1:0];
              state <= BACKOFF;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BACKOFF: begin
          Packet_From_Node_Valid <= 1'b1;
          timer                  <= '0;
          state                  <= OFFER;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- inbound FIFO ----------------
  logic [23:0]    rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wr, rx_rd;
  logic [RXA:0]   rx_cnt;
  logic           rx_full, rx_push, rx_pop, rx_drop;

  // Fullness uses the registered count; a same-cycle pop frees no space.
  assign rx_full      = (rx_cnt == (RXA+1)'(RX_DEPTH));
  assign rx_push      = Packet_To_Node_Valid && !rx_full;
  assign rx_drop      = Packet_To_Node_Valid && rx_full;
  assign app_rx_valid = (rx_cnt != '0);
  assign rx_pop       = app_rx_valid && app_rx_ready;
  // Head is forced to zero when empty so stale storage never shows.
  assign app_rx_data  = app_rx_valid ? rx_mem[rx_rd] : '0;

  always_ff @(posedge Clk_R) begin
    if (rx_push) rx_mem[rx_wr] <= Packet_To_Node;
  end

  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_cnt      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RXA'(1);
      if (rx_pop)  rx_rd <= rx_rd + RXA'(1);
      if (rx_drop) rx_overflow <= 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RXA+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RXA+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef NODE_PORT_STATS_EN
  // ---------------- saturating statistics ----------------
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      stat_tx_sent  <= '0;
      stat_tx_retry <= '0;
      stat_tx_drop  <= '0;
      stat_rx_drop  <= '0;
    end else begin
      if (ack_hit && stat_tx_sent != '1)                 stat_tx_sent  <= stat_tx_sent + 16'd1;
      if (timeout && !last_try && stat_tx_retry != '1)   stat_tx_retry <= stat_tx_retry + 16'd1;
      if (timeout && last_try && stat_tx_drop != '1)     stat_tx_drop  <= stat_tx_drop + 16'd1;
      if (rx_drop && stat_rx_drop != '1)                 stat_rx_drop  <= stat_rx_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_node_port_ctrl.sv
// Self-checking bench for node_port_ctrl: directed sequences, an RX vector
// table, and a randomized run against a timing-arithmetic reference model.
module tb_node_port_ctrl;

  localparam int ACK_TIMEOUT = 16;
  localparam int MAX_RETRY   = 3;
  localparam int DEPTH       = 4;

  logic        Clk_R = 1'b0;
  logic        Rst;
  logic [28:0] app_tx_data;
  logic        app_tx_valid;
  logic        app_tx_ready;
  logic [28:0] Packet_From_Node;
  logic        Packet_From_Node_Valid;
  logic        Core_Load_Ack;
  logic [23:0] Packet_To_Node;
  logic        Packet_To_Node_Valid;
  logic [23:0] app_rx_data;
  logic        app_rx_valid;
  logic        app_rx_ready;
  logic        tx_err;
  logic        rx_overflow;

  node_port_ctrl #(
    .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .Clk_R(Clk_R), .Rst(Rst),
    .app_tx_data(app_tx_data), .app_tx_valid(app_tx_valid), .app_tx_ready(app_tx_ready),
    .Packet_From_Node(Packet_From_Node), .Packet_From_Node_Valid(Packet_From_Node_Valid),
    .Core_Load_Ack(Core_Load_Ack),
    .Packet_To_Node(Packet_To_Node), .Packet_To_Node_Valid(Packet_To_Node_Valid),
    .app_rx_data(app_rx_data), .app_rx_valid(app_rx_valid), .app_rx_ready(app_rx_ready),
    .tx_err(tx_err), .rx_overflow(rx_overflow)
  );

  always #5 Clk_R = ~Clk_R;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clk_R);
    #1;
  endtask

  task automatic clear_inputs();
    app_tx_data = '0; app_tx_valid = 1'b0; Core_Load_Ack = 1'b0;
    Packet_To_Node = '0; Packet_To_Node_Valid = 1'b0; app_rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
  endtask

  // Inbound vector: inputs for a cycle and the outputs expected in that cycle.
  typedef struct {
    logic        in_v;
    logic [23:0] in_d;
    logic        rdy;
    logic        exp_v;
    logic [23:0] exp_d;
    logic        exp_ovf;
  } rx_vec_t;

  // Reference model records.
  typedef struct {
    logic [28:0] d;
    int          avail;   // first cycle this packet can be on the wire
  } txe_t;

  logic [28:0] pk [4];
  logic        rec_v   [60];
  logic        rec_err [60];
  logic [28:0] rec_d   [60];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_vec_t vec [10];
    clear_inputs();
    Rst = 1'b1;
    #1;
    do_reset();

    // ---- reset state ----
    chk("rst_valid", 32'(Packet_From_Node_Valid), 32'd0);
    chk("rst_pkt",   32'(Packet_From_Node), 32'd0);
    chk("rst_err",   32'(tx_err), 32'd0);
    chk("rst_ovf",   32'(rx_overflow), 32'd0);
    chk("rst_rxv",   32'(app_rx_valid), 32'd0);
    chk("rst_rxd",   32'(app_rx_data), 32'd0);
    chk("rst_ready", 32'(app_tx_ready), 32'd1);

    // ---- single packet, ack on first offer cycle ----
    app_tx_data = 29'h1ABCDEF; app_tx_valid = 1'b1;
    step();                                        // c1
    app_tx_valid = 1'b0;
    chk("t1_c1_valid", 32'(Packet_From_Node_Valid), 32'd0);
    step();                                        // c2
    chk("t1_c2_valid", 32'(Packet_From_Node_Valid), 32'd1);
    chk("t1_c2_data",  32'(Packet_From_Node), 32'h1ABCDEF);
    Core_Load_Ack = 1'b1;
    step();                                        // c3
    Core_Load_Ack = 1'b0;
    chk("t1_c3_valid", 32'(Packet_From_Node_Valid), 32'd0);
    chk("t1_c3_err",   32'(tx_err), 32'd0);
    chk("t1_c3_ready", 32'(app_tx_ready), 32'd1);
    step();
    chk("t1_c4_valid", 32'(Packet_From_Node_Valid), 32'd0);

    // ---- four packets, ack in the 4th cycle of each offer ----
    pk[0] = 29'h0000111; pk[1] = 29'h0AAA222; pk[2] = 29'h1555333; pk[3] = 29'h1FFF444;
    for (int i = 0; i < 4; i++) begin              // pushes in c0..c3
      app_tx_data = pk[i]; app_tx_valid = 1'b1;
      if (i >= 2) begin
        chk("t2_first_valid", 32'(Packet_From_Node_Valid), 32'd1);
        chk("t2_first_data",  32'(Packet_From_Node), 32'(pk[0]));
      end
      step();
    end
    app_tx_valid = 1'b0;                           // c4
    chk("t2_full_ready", 32'(app_tx_ready), 32'd0);
    chk("t2_c4_data",    32'(Packet_From_Node), 32'(pk[0]));
    step();                                        // c5: 4th offer cycle
    chk("t2_c5_valid", 32'(Packet_From_Node_Valid), 32'd1);
    Core_Load_Ack = 1'b1;
    step();
    Core_Load_Ack = 1'b0;
    chk("t2_gap0", 32'(Packet_From_Node_Valid), 32'd0);
    chk("t2_ready_after_pop", 32'(app_tx_ready), 32'd1);
    step();
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("t2_valid", 32'(Packet_From_Node_Valid), 32'd1);
        chk("t2_data",  32'(Packet_From_Node), 32'(pk[k]));
        if (j == 3) Core_Load_Ack = 1'b1;
        step();
      end
      Core_Load_Ack = 1'b0;
      chk("t2_gap", 32'(Packet_From_Node_Valid), 32'd0);
      step();
    end
    chk("t2_drained", 32'(Packet_From_Node_Valid), 32'd0);

    // ---- no ack: three 16-cycle windows, then discard and next packet ----
    pk[0] = 29'h0C0FFEE; pk[1] = 29'h1234567;
    for (int t = 0; t < 60; t++) begin
      rec_v[t] = Packet_From_Node_Valid; rec_err[t] = tx_err; rec_d[t] = Packet_From_Node;
      app_tx_valid = (t < 2);
      app_tx_data  = (t == 0) ? pk[0] : pk[1];
      step();
    end
    for (int t = 0; t < 60; t++) begin
      automatic logic ev = (t >= 2 && t <= 17) || (t >= 19 && t <= 34) ||
                           (t >= 36 && t <= 51) || (t >= 53);
      chk("t3_valid", 32'(rec_v[t]), 32'(ev));
      chk("t3_err",   32'(rec_err[t]), (t == 52) ? 32'd1 : 32'd0);
      if (t >= 2 && t <= 51) chk("t3_data_p1", 32'(rec_d[t]), 32'(pk[0]));
      if (t >= 53)           chk("t3_data_p2", 32'(rec_d[t]), 32'(pk[1]));
    end
    Core_Load_Ack = 1'b1;
    step();
    Core_Load_Ack = 1'b0;
    chk("t3_p2_acked", 32'(Packet_From_Node_Valid), 32'd0);
    step();

    // ---- ack exactly in the 16th offer cycle; stray ack while idle ----
    app_tx_data = 29'h0BADA55; app_tx_valid = 1'b1;
    step();
    app_tx_valid = 1'b0;
    step();                                        // c2
    for (int j = 0; j < ACK_TIMEOUT; j++) begin
      chk("t4_valid", 32'(Packet_From_Node_Valid), 32'd1);
      if (j == ACK_TIMEOUT - 1) Core_Load_Ack = 1'b1;
      step();
    end
    Core_Load_Ack = 1'b0;                          // c18
    chk("t4_c18_valid", 32'(Packet_From_Node_Valid), 32'd0);
    chk("t4_c18_err",   32'(tx_err), 32'd0);
    step();
    chk("t4_no_backoff", 32'(Packet_From_Node_Valid), 32'd0);
    Core_Load_Ack = 1'b1;                          // ignored outside an offer
    step();
    Core_Load_Ack = 1'b0;
    chk("t4_idle_ack_valid", 32'(Packet_From_Node_Valid), 32'd0);
    app_tx_data = 29'h0777777; app_tx_valid = 1'b1;
    step();
    app_tx_valid = 1'b0;
    step();
    chk("t4_next_valid", 32'(Packet_From_Node_Valid), 32'd1);
    chk("t4_next_data",  32'(Packet_From_Node), 32'h0777777);
    Core_Load_Ack = 1'b1;
    step();
    Core_Load_Ack = 1'b0;
    step();

    // ---- inbound overflow table ----
    vec[0] = '{1'b1, 24'h000001, 1'b0, 1'b0, 24'h0, 1'b0};
    vec[1] = '{1'b1, 24'h000002, 1'b0, 1'b1, 24'h1, 1'b0};
    vec[2] = '{1'b1, 24'h000003, 1'b0, 1'b1, 24'h1, 1'b0};
    vec[3] = '{1'b1, 24'h000004, 1'b0, 1'b1, 24'h1, 1'b0};
    vec[4] = '{1'b1, 24'h000005, 1'b0, 1'b1, 24'h1, 1'b0};
    vec[5] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h1, 1'b1};
    vec[6] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h2, 1'b1};
    vec[7] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h3, 1'b1};
    vec[8] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h4, 1'b1};
    vec[9] = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      Packet_To_Node_Valid = vec[i].in_v;
      Packet_To_Node       = vec[i].in_d;
      app_rx_ready         = vec[i].rdy;
      chk("t5_rx_valid", 32'(app_rx_valid), 32'(vec[i].exp_v));
      chk("t5_rx_data",  32'(app_rx_data),  32'(vec[i].exp_d));
      chk("t5_ovf",      32'(rx_overflow),  32'(vec[i].exp_ovf));
      step();
    end
    clear_inputs();

    // ---- reset in the middle of an offer ----
    for (int i = 0; i < 3; i++) begin
      app_tx_data = 29'(32'h100 + i); app_tx_valid = 1'b1;
      Packet_To_Node = 24'hABCDEF; Packet_To_Node_Valid = (i == 0);
      step();
    end
    clear_inputs();
    step();                                        // c4: offering
    chk("t6_pre_valid", 32'(Packet_From_Node_Valid), 32'd1);
    chk("t6_pre_rxv",   32'(app_rx_valid), 32'd1);
    #3 Rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(Packet_From_Node_Valid), 32'd0);
    chk("t6_async_ready", 32'(app_tx_ready), 32'd1);
    chk("t6_async_rxv",   32'(app_rx_valid), 32'd0);
    chk("t6_async_ovf",   32'(rx_overflow), 32'd0);
    step();
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_offer", 32'(Packet_From_Node_Valid), 32'd0);
    end
    app_tx_data = 29'h0055AA5; app_tx_valid = 1'b1;
    step();
    app_tx_valid = 1'b0;
    step();
    chk("t6_new_valid", 32'(Packet_From_Node_Valid), 32'd1);
    chk("t6_new_data",  32'(Packet_From_Node), 32'h0055AA5);

    // ---- randomized run against the reference model ----
    clear_inputs();
    do_reset();
    begin
      txe_t        q[$];
      logic [23:0] rq[$];
      int earliest = 0, a_start = -1, tries = 0, err_at = -1;
      logic m_ovf = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        automatic logic m_valid, ready, push, ack, rxfull;
        automatic int rate = ((t / 500) % 2 == 1) ? 4 : 24;
        if (a_start < 0 && q.size() > 0 && t >= earliest && t >= q[0].avail) begin
          a_start = t;
          tries   = 0;
        end
        m_valid = (a_start >= 0) && (t >= a_start);
        ready   = (q.size() < DEPTH);
        chk("r_valid", 32'(Packet_From_Node_Valid), 32'(m_valid));
        if (m_valid) chk("r_data", 32'(Packet_From_Node), 32'(q[0].d));
        chk("r_err",   32'(tx_err), (err_at == t) ? 32'd1 : 32'd0);
        chk("r_ready", 32'(app_tx_ready), 32'(ready));
        chk("r_rxv",   32'(app_rx_valid), (rq.size() > 0) ? 32'd1 : 32'd0);
        chk("r_rxd",   32'(app_rx_data), (rq.size() > 0) ? 32'(rq[0]) : 32'd0);
        chk("r_ovf",   32'(rx_overflow), 32'(m_ovf));

        push = ($urandom % 2) == 0;
        ack  = ($urandom % rate) == 0;
        app_tx_valid = push;
        app_tx_data  = 29'($urandom);
        Core_Load_Ack = ack;
        Packet_To_Node_Valid = ($urandom % 3) == 0;
        Packet_To_Node       = 24'($urandom);
        app_rx_ready         = ($urandom % 4) == 0;

        if (m_valid) begin
          if (ack) begin
            void'(q.pop_front());
            earliest = t + 2;
            a_start  = -1;
          end else if (t - a_start == ACK_TIMEOUT - 1) begin
            tries++;
            if (tries == MAX_RETRY) begin
              void'(q.pop_front());
              err_at   = t + 1;
              earliest = t + 2;
              a_start  = -1;
            end else begin
              a_start = t + 2;
            end
          end
        end
        if (push && ready) q.push_back('{app_tx_data, t + 2});

        rxfull = (rq.size() == DEPTH);
        if (rq.size() > 0 && app_rx_ready) void'(rq.pop_front());
        if (Packet_To_Node_Valid) begin
          if (rxfull) m_ovf = 1'b1;
          else        rq.push_back(Packet_To_Node);
        end
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
